// File: rtl/mastermind_scorer_if.sv
// Handshake and result bundle between the mastermind game controller and its scoring engine.
interface mastermind_scorer_if #(
  parameter int PEG_W = 3
) ();
  logic               start;
  logic               new_game;
  logic [4*PEG_W-1:0] code;
  logic [4*PEG_W-1:0] guess;
  logic               busy;
  logic               done;
  logic [2:0]         red;
  logic [2:0]         white;
  logic [3:0]         guess_num;
  logic               win;
  logic               lose;

  modport master (
    output start, new_game, code, guess,
    input  busy, done, red, white, guess_num, win, lose
  );

  modport slave (
    input  start, new_game, code, guess,
    output busy, done, red, white, guess_num, win, lose
  );
endinterface

// File: rtl/mastermind_scorer.sv
// Multi-cycle mastermind scorer: red pass, white pass over unused pegs, then result and win/lose update.
module mastermind_scorer #(
  parameter int PEG_W       = 3,
  parameter int MAX_GUESSES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mastermind_scorer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RED, WHITE, FINISH} state_e;

  localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);

  state_e             state_q;
  logic [4*PEG_W-1:0] code_q, guess_q;
  logic [2:0]         red_cnt_q, white_cnt_q, red_q, white_q;
  logic [3:0]         code_used_q, guess_used_q, guess_num_q;
  logic [1:0]         idx_q;
  logic [3:0]         pair_q;
  logic               busy_q, done_q, win_q, lose_q;

  logic [3:0]         guess_num_d;
  logic [1:0]         g_idx, c_idx;
  logic               red_hit, white_hit, game_over;

  function automatic logic [PEG_W-1:0] peg(input logic [4*PEG_W-1:0] v, input logic [1:0] i);
    return v[PEG_W*i +: PEG_W];
  endfunction

  // The white pass walks guess peg g (outer) against code peg c (inner).
  assign g_idx       = pair_q[3:2];
  assign c_idx       = pair_q[1:0];
  assign red_hit     = peg(code_q, idx_q) == peg(guess_q, idx_q);
  assign white_hit   = !guess_used_q[g_idx] && !code_used_q[c_idx]
                       && (peg(guess_q, g_idx) == peg(code_q, c_idx));
  assign guess_num_d = guess_num_q + 4'd1;
  assign game_over   = win_q | lose_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      code_q       <= '0;
      guess_q      <= '0;
      red_cnt_q    <= '0;
      white_cnt_q  <= '0;
      red_q        <= '0;
      white_q      <= '0;
      code_used_q  <= '0;
      guess_used_q <= '0;
      guess_num_q  <= '0;
      idx_q        <= '0;
      pair_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.new_game) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        red_q       <= '0;
        white_q     <= '0;
        guess_num_q <= '0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !game_over) begin
              code_q       <= bus.code;
              guess_q      <= bus.guess;
              red_cnt_q    <= '0;
              white_cnt_q  <= '0;
              code_used_q  <= '0;
              guess_used_q <= '0;
              idx_q        <= '0;
              pair_q       <= '0;
              busy_q       <= 1'b1;
              state_q      <= RED;
            end
          end
          RED: begin
            if (red_hit) begin
              red_cnt_q           <= red_cnt_q + 3'd1;
              code_used_q[idx_q]  <= 1'b1;
              guess_used_q[idx_q] <= 1'b1;
            end
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              pair_q  <= '0;
              state_q <= WHITE;
            end
          end
          WHITE: begin
            // Marking guess peg g used stops it from matching a second code peg.
            if (white_hit) begin
              white_cnt_q         <= white_cnt_q + 3'd1;
              guess_used_q[g_idx] <= 1'b1;
              code_used_q[c_idx]  <= 1'b1;
            end
            pair_q <= pair_q + 4'd1;
            if (pair_q == 4'd15) state_q <= FINISH;
          end
          FINISH: begin
            red_q       <= red_cnt_q;
            white_q     <= white_cnt_q;
            guess_num_q <= guess_num_d;
            win_q       <= red_cnt_q == 3'd4;
            lose_q      <= (red_cnt_q != 3'd4) && (guess_num_d == MAX_G);
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.red       = red_q;
  assign bus.white     = white_q;
  assign bus.guess_num = guess_num_q;
  assign bus.win       = win_q;
  assign bus.lose      = lose_q;

endmodule
